// File: rtl/dither_unpacker_pkg.sv
// dither_unpacker_pkg: shared state encoding, frame defaults, counter widths and gray levels
package dither_unpacker_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int H_ACTIVE_DEF = 320;
  localparam int V_ACTIVE_DEF = 180;
  localparam int HC_W = 11;
  localparam int VC_W = 10;
  localparam logic [7:0] GRAY_BLACK = 8'd0;
  localparam logic [7:0] GRAY_WHITE = 8'd255;
endpackage

// File: rtl/dither_unpacker.sv
// dither_unpacker: expands packed 1-bit dithered bytes into a raster-ordered pixel stream
module dither_unpacker
  import dither_unpacker_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF
) (
  input  logic            clk_in,
  input  logic            rst_in,
  input  logic [7:0]      byte_data,
  input  logic            byte_sof,
  input  logic            byte_valid,
  output logic            byte_ready,
  output logic            pixel_bit,
  output logic [7:0]      pixel_gray,
  output logic [HC_W-1:0] pixel_hcount,
  output logic [VC_W-1:0] pixel_vcount,
  output logic            pixel_valid,
  input  logic            pixel_ready,
  output logic            frame_done,
  output logic            sync_error
);
  localparam logic [HC_W-1:0] H_LAST = HC_W'(H_ACTIVE - 1);
  localparam logic [VC_W-1:0] V_LAST = VC_W'(V_ACTIVE - 1);
  state_t state_q, state_d;
  logic [7:0] sr_q, sr_d;
  logic [2:0] idx_q, idx_d;
  logic full_q, full_d;
  logic [HC_W-1:0] hcount_q, hcount_d;
  logic [VC_W-1:0] vcount_q, vcount_d;
  logic frame_done_q, frame_done_d;
  logic sync_error_q, sync_error_d;
  logic pix_xfer, h_last, last_bit, frame_end, byte_acc, run_on;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      sr_q         <= '0;
      idx_q        <= '0;
      full_q       <= 1'b0;
      hcount_q     <= '0;
      vcount_q     <= '0;
      frame_done_q <= 1'b0;
      sync_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      idx_q        <= idx_d;
      full_q       <= full_d;
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      frame_done_q <= frame_done_d;
      sync_error_q <= sync_error_d;
    end
  end
  // a byte's last used bit is bit 0 or the row's final pixel; later bits are row padding
  always_comb begin
    pix_xfer  = full_q && pixel_ready;
    h_last    = hcount_q == H_LAST;
    last_bit  = idx_q == 3'd7 || h_last;
    frame_end = pix_xfer && h_last && vcount_q == V_LAST;
    byte_acc  = byte_valid && byte_ready;
    run_on    = state_q == RUN && !frame_end;
  end
  always_comb begin
    state_d      = state_q;
    sr_d         = sr_q;
    idx_d        = idx_q;
    full_d       = full_q;
    hcount_d     = hcount_q;
    vcount_d     = vcount_q;
    frame_done_d = 1'b0;
    sync_error_d = 1'b0;
    if (pix_xfer) begin
      idx_d    = idx_q + 3'd1;
      full_d   = !last_bit;
      hcount_d = h_last ? '0 : hcount_q + 1'b1;
      vcount_d = h_last ? vcount_q + 1'b1 : vcount_q;
    end
    if (frame_end) begin
      state_d      = IDLE;
      full_d       = 1'b0;
      hcount_d     = '0;
      vcount_d     = '0;
      frame_done_d = 1'b1;
    end
    // a byte landing on the frame's last transfer is judged as if already in IDLE
    if (byte_acc && (byte_sof || run_on)) begin
      state_d = RUN;
      sr_d    = byte_data;
      idx_d   = '0;
      full_d  = 1'b1;
    end
    if (byte_acc && byte_sof) begin
      hcount_d     = '0;
      vcount_d     = '0;
      sync_error_d = run_on;
    end
  end
  always_comb begin
    byte_ready   = rst_in && (state_q == IDLE || !full_q || (pix_xfer && last_bit));
    pixel_valid  = full_q;
    pixel_bit    = full_q && sr_q[3'd7 - idx_q];
    pixel_gray   = !full_q ? 8'd0 : pixel_bit ? GRAY_BLACK : GRAY_WHITE;
    pixel_hcount = hcount_q;
    pixel_vcount = vcount_q;
    frame_done   = frame_done_q;
    sync_error   = sync_error_q;
  end
endmodule

// File: tb/tb_dither_unpacker.sv
// tb_dither_unpacker: directed checks of dither_unpacker on a 12x2 frame (row padding exercised)
module tb_dither_unpacker;
  logic clk_in = 1'b0;
  logic rst_in = 1'b0;
  logic [7:0] byte_data = '0;
  logic byte_sof = 1'b0;
  logic byte_valid = 1'b0;
  logic byte_ready;
  logic pixel_bit;
  logic [7:0] pixel_gray;
  logic [10:0] pixel_hcount;
  logic [9:0] pixel_vcount;
  logic pixel_valid;
  logic pixel_ready = 1'b1;
  logic frame_done;
  logic sync_error;
  dither_unpacker #(.H_ACTIVE(12), .V_ACTIVE(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .byte_data(byte_data), .byte_sof(byte_sof),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .pixel_bit(pixel_bit),
    .pixel_gray(pixel_gray), .pixel_hcount(pixel_hcount), .pixel_vcount(pixel_vcount),
    .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .frame_done(frame_done),
    .sync_error(sync_error)
  );
  always #5 clk_in = ~clk_in;
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  logic rec_bits [0:127];
  int rec_h [0:127];
  int rec_v [0:127];
  int rec_n = 0, fd_cnt = 0, se_cnt = 0, gray_bad = 0, stall_bad = 0;
  logic stall_p = 1'b0, bit_p = 1'b0;
  logic [10:0] h_p = '0;
  logic [9:0] v_p = '0;
  logic rnd = 1'b0;
  always @(negedge clk_in) begin
    if (stall_p && (!pixel_valid || pixel_bit !== bit_p || pixel_hcount !== h_p || pixel_vcount !== v_p))
      stall_bad++;
    stall_p = pixel_valid && !pixel_ready;
    bit_p = pixel_bit;
    h_p = pixel_hcount;
    v_p = pixel_vcount;
    if (pixel_valid && pixel_ready) begin
      if (rec_n < 128) begin
        rec_bits[rec_n] = pixel_bit;
        rec_h[rec_n] = int'(pixel_hcount);
        rec_v[rec_n] = int'(pixel_vcount);
      end
      if (pixel_gray !== (pixel_bit ? 8'd0 : 8'd255)) gray_bad++;
      rec_n++;
    end
    if (frame_done) fd_cnt++;
    if (sync_error) se_cnt++;
  end
  always @(posedge clk_in) if (rnd) begin
    #1 pixel_ready = 1'($urandom_range(0, 1));
  end
  task automatic clear();
    rec_n = 0;
    fd_cnt = 0;
    se_cnt = 0;
    gray_bad = 0;
    stall_bad = 0;
  endtask
  task automatic send(input logic [7:0] d, input logic s);
    int t = 0;
    byte_data = d;
    byte_sof = s;
    byte_valid = 1'b1;
    @(negedge clk_in);
    while (!byte_ready && t < 500) begin
      @(negedge clk_in);
      t++;
    end
    @(posedge clk_in);
    #1;
    byte_valid = 1'b0;
    byte_sof = 1'b0;
  endtask
  task automatic wait_fd(input int n);
    int t = 0;
    while (fd_cnt < n && t < 2000) begin
      @(posedge clk_in);
      t++;
    end
    repeat (3) @(posedge clk_in);
    #1;
  endtask
  function automatic logic [63:0] seq(input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v = {v[62:0], rec_bits[i]};
    return v;
  endfunction
  function automatic int hv_err(input int from, input int to);
    int e = 0;
    for (int i = from; i < to; i++)
      if (rec_h[i] != (i - from) % 12 || rec_v[i] != ((i - from) / 12) % 2) e++;
    return e;
  endfunction
  initial begin
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_byte_ready", byte_ready, 0);
    chk("rst_pixel_valid", pixel_valid, 0);
    chk("rst_pixel_gray", pixel_gray, 0);
    chk("rst_pixel_bit", pixel_bit, 0);
    chk("rst_pulses", {frame_done, sync_error}, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    clear();
    send(8'hA5, 1); send(8'h0F, 0); send(8'hFF, 0); send(8'h00, 0);
    wait_fd(1);
    chk("a_count", rec_n, 24);
    chk("a_bits", seq(24), {12'b1010_0101_0000, 12'b1111_1111_0000});
    chk("a_hv", hv_err(0, 24), 0);
    chk("a_last_hv", {rec_h[23][15:0], rec_v[23][15:0]}, {16'd11, 16'd1});
    chk("a_gray", gray_bad, 0);
    chk("a_frame_done", fd_cnt, 1);
    chk("a_sync_err", se_cnt, 0);
    clear();
    send(8'hA5, 1); send(8'h0F, 0); send(8'hFF, 0); send(8'h00, 0);
    send(8'h80, 1); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    wait_fd(2);
    chk("b2b_count", rec_n, 48);
    chk("b2b_bits", seq(48), {12'b1010_0101_0000, 12'b1111_1111_0000, 12'b1000_0000_0000, 12'b0});
    chk("b2b_hv", hv_err(0, 48), 0);
    chk("b2b_frame_done", fd_cnt, 2);
    chk("b2b_sync_err", se_cnt, 0);
    clear();
    rnd = 1'b1;
    send(8'hA5, 1); send(8'h0F, 0); send(8'hFF, 0); send(8'h00, 0);
    wait_fd(1);
    rnd = 1'b0;
    @(posedge clk_in);
    #2 pixel_ready = 1'b1;
    chk("stall_count", rec_n, 24);
    chk("stall_bits", seq(24), {12'b1010_0101_0000, 12'b1111_1111_0000});
    chk("stall_hv", hv_err(0, 24), 0);
    chk("stall_stable", stall_bad, 0);
    chk("stall_frame_done", fd_cnt, 1);
    clear();
    send(8'hFF, 0); send(8'hFF, 0);
    send(8'h80, 1); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    wait_fd(1);
    chk("idle_count", rec_n, 24);
    chk("idle_bits", seq(24), {12'b1000_0000_0000, 12'b0});
    chk("idle_frame_done", fd_cnt, 1);
    clear();
    send(8'hFF, 1); send(8'h00, 0);
    send(8'hC3, 1); send(8'h0F, 0); send(8'hFF, 0); send(8'hF0, 0);
    wait_fd(1);
    chk("sync_count", rec_n, 36);
    chk("sync_bits", seq(36), {12'b1111_1111_0000, 12'b1100_0011_0000, 12'b1111_1111_1111});
    chk("sync_hv_old", hv_err(0, 12), 0);
    chk("sync_hv_new", hv_err(12, 36), 0);
    chk("sync_err_pulse", se_cnt, 1);
    chk("sync_frame_done", fd_cnt, 1);
    clear();
    send(8'hFF, 1); send(8'hFF, 0);
    chk("pre_rst_valid", pixel_valid, 1);
    #3 rst_in = 1'b0;
    #1;
    chk("mid_rst_valid", pixel_valid, 0);
    chk("mid_rst_ready", byte_ready, 0);
    chk("mid_rst_bit_gray", {pixel_bit, pixel_gray}, 0);
    chk("mid_rst_counts", {pixel_hcount, pixel_vcount}, 0);
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    clear();
    send(8'hFF, 0); send(8'hAA, 0);
    repeat (20) @(posedge clk_in);
    #1;
    chk("post_rst_ignored", rec_n, 0);
    chk("post_rst_idle_ready", byte_ready, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dither_unpacker.md
DITHER_UNPACKER -- requirements
Module: dither_unpacker

Interface
REQ-001 Parameter H_ACTIVE, default 320, pixels per row (1..2047).
REQ-002 Parameter V_ACTIVE, default 180, rows per frame (1..1023).
REQ-003 clk_in  input  1  sole clock; all logic on rising edge.
REQ-004 rst_in  input  1  asynchronous, active-low reset.
REQ-005 byte_data  input  8  packed 1-bit dithered pixels, MSB = leftmost pixel.
REQ-006 byte_sof  input  1  qualifies byte_data as first byte of a frame.
REQ-007 byte_valid  input  1  byte_data/byte_sof valid.
REQ-008 byte_ready  output  1  block accepts byte this cycle.
REQ-009 pixel_bit  output  1  unpacked dither bit (1 = black).
REQ-010 pixel_gray  output  8  bit 1 -> 8'd0, bit 0 -> 8'd255.
REQ-011 pixel_hcount  output  11  column of current pixel.
REQ-012 pixel_vcount  output  10  row of current pixel.
REQ-013 pixel_valid  output  1  pixel outputs valid.
REQ-014 pixel_ready  input  1  downstream accepts pixel.
REQ-015 frame_done  output  1  one-cycle pulse after last pixel of frame accepted.
REQ-016 sync_error  output  1  one-cycle pulse on premature byte_sof.

Function
REQ-017 Byte transfer SHALL occur when byte_valid && byte_ready; pixel transfer when pixel_valid && pixel_ready.
REQ-018 FSM states SHALL be IDLE, RUN; reset enters IDLE.
REQ-019 IDLE: byte_ready=1; bytes with byte_sof=0 SHALL be consumed and discarded; byte with byte_sof=1 SHALL be loaded, counters set to (0,0), go RUN.
REQ-020 RUN: shift register holds current byte; bit index 0..7 selects bit 7-index as pixel_bit.
REQ-021 First pixel of an accepted byte SHALL be valid the cycle after acceptance (latency 1).
REQ-022 pixel_* outputs SHALL hold stable while pixel_valid && !pixel_ready.
REQ-023 byte_ready in RUN SHALL be 1 when shift register empty, or when its last used bit is being transferred this cycle (zero-bubble back-to-back bytes).
REQ-024 Rows SHALL start on a byte boundary; when H_ACTIVE%8!=0 the unused low bits of each row's final byte SHALL be discarded without pixel_valid.
REQ-025 pixel_hcount SHALL increment per pixel transfer, wrapping H_ACTIVE-1 -> 0 with pixel_vcount +1.
REQ-026 Transfer of pixel (H_ACTIVE-1, V_ACTIVE-1) SHALL pulse frame_done next cycle, empty the shift register, return to IDLE.
REQ-027 byte_sof=1 accepted in RUN before frame end SHALL abort the frame, pulse sync_error, load that byte as pixel (0,0); no frame_done for the aborted frame.
REQ-028 byte_sof=1 on a byte arriving exactly as the last pixel transfers SHALL be treated as a normal new frame (no sync_error).
REQ-029 Simultaneous frame end and byte acceptance SHALL not drop or duplicate pixels.

Reset
REQ-030 On rst_in=0: state IDLE, counters 0, shift register empty, pixel_valid=0, pixel_bit=0, pixel_gray=0, frame_done=0, sync_error=0; byte_ready=0 while asserted.
REQ-031 Reset mid-frame SHALL discard the partial frame; after release, output resumes only on next byte_sof.

Structure
REQ-032 Shared package SHALL hold state enum, default H_ACTIVE/V_ACTIVE, and gray constants GRAY_BLACK=0, GRAY_WHITE=255 shared with dither stage.
REQ-033 Single module; no sub-module required; counter width derived from package.

Verification
REQ-034 H=16,V=2, bytes 8'hA5(sof),8'h0F,8'hFF,8'h00, ready=1 -> bits 1,0,1,0,0,1,0,1,0,0,0,0,1,1,1,1,...; gray 0/255 accordingly; frame_done once after (15,1).
REQ-035 H=12,V=1, bytes 8'hFF(sof),8'hF0 -> 12 pixels, all gray 0; 4 pad bits emit nothing; frame_done.
REQ-036 Random pixel_ready toggling (50%) on H=320,V=180 -> pixel sequence identical to ready=1 run; outputs stable while stalled.
REQ-037 Two bytes without sof in IDLE then sof byte 8'h80 -> first two discarded; pixel (0,0) bit 1.
REQ-038 sof asserted on byte 5 of frame -> sync_error pulse, counters restart (0,0), no frame_done.
REQ-039 rst_in low at pixel (100,50) -> all outputs to reset values immediately; post-release, non-sof bytes ignored.
